// File: rtl/sram_arb_pkg.sv
// Shared types for the firmware-SRAM bus arbiter.
// Defines the FSM state encoding, the master IDs and the read-strobe constant.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  // Byte address to SRAM word index; the two byte-lane bits are dropped.
  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant select for the SRAM arbiter.
// SRAM_ARB_RR_EN selects round-robin on contention; otherwise m0 has fixed priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic    valid0,
  input  logic    valid1,
`ifdef SRAM_ARB_RR_EN
  input  master_t last,
`endif
  output master_t grant
);

  always_comb begin
    grant = M0;
    if (valid0 && valid1) begin
`ifdef SRAM_ARB_RR_EN
      // Contention goes to whichever master was not served last.
      grant = (last == M0) ? M1 : M0;
`else
      grant = M0;
`endif
    end else if (valid1) begin
      grant = M1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter for the single-port firmware SRAM: IDLE -> ISSUE -> RESP per transaction.
// Optional round-robin arbitration via SRAM_ARB_RR_EN (fixed m0 priority when undefined).
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_valid,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic             m0_ready,
  output logic [31:0]      m0_rdata,
  input  logic             m1_valid,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic             m1_ready,
  output logic [31:0]      m1_rdata,
  output logic             sram_en,
  output logic [29:0]      sram_idx,
  output logic [31:0]      sram_wdata,
  output logic [3:0]       sram_wstrb,
  input  logic [31:0]      sram_rdata,
  output logic             bus_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  state_t           state_reg;
  master_t          grant_reg;
  master_t          pick_grant;
  logic [29:0]      idx_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;
  logic             in_range_reg;
  logic             sram_en_reg;
  logic             ready0_reg;
  logic             ready1_reg;
  logic             bus_err_reg;
  logic [CNT_W-1:0] cnt0_reg;
  logic [CNT_W-1:0] cnt1_reg;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic [29:0]      sel_idx;
  logic             sel_in_range;
  logic             resp_read;
`ifdef SRAM_ARB_RR_EN
  master_t          last_reg;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  sram_arb_pick u_pick (
    .valid0(m0_valid),
    .valid1(m1_valid),
`ifdef SRAM_ARB_RR_EN
    .last  (last_reg),
`endif
    .grant (pick_grant)
  );

  always_comb begin
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wstrb = m0_wstrb;
    if (pick_grant == M1) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wstrb = m1_wstrb;
    end
    sel_idx      = word_idx(sel_addr);
    sel_in_range = ({2'b00, sel_idx} < 32'(MEM_WORDS));
  end

  // The request is captured at grant time so a master dropping valid mid-flight still completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= M0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= WSTRB_READ;
      in_range_reg <= 1'b0;
      sram_en_reg  <= 1'b0;
      ready0_reg   <= 1'b0;
      ready1_reg   <= 1'b0;
      bus_err_reg  <= 1'b0;
      cnt0_reg     <= '0;
      cnt1_reg     <= '0;
`ifdef SRAM_ARB_RR_EN
      last_reg     <= M1;
`endif
    end else begin
      sram_en_reg <= 1'b0;
      ready0_reg  <= 1'b0;
      ready1_reg  <= 1'b0;
      bus_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_reg    <= pick_grant;
            idx_reg      <= sel_idx;
            wdata_reg    <= sel_wdata;
            wstrb_reg    <= sel_wstrb;
            in_range_reg <= sel_in_range;
            sram_en_reg  <= sel_in_range;
            state_reg    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ready0_reg  <= (grant_reg == M0);
          ready1_reg  <= (grant_reg == M1);
          bus_err_reg <= !in_range_reg;
          state_reg   <= ST_RESP;
        end
        ST_RESP: begin
          if (grant_reg == M0) cnt0_reg <= sat_inc(cnt0_reg);
          else                 cnt1_reg <= sat_inc(cnt1_reg);
`ifdef SRAM_ARB_RR_EN
          last_reg  <= grant_reg;
`endif
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sram_en    = sram_en_reg;
  assign sram_idx   = idx_reg;
  assign sram_wdata = wdata_reg;
  assign sram_wstrb = sram_en_reg ? wstrb_reg : WSTRB_READ;

  // SRAM read data arrives during RESP, so it is steered combinationally.
  assign resp_read  = (wstrb_reg == WSTRB_READ) && in_range_reg;
  assign m0_ready   = ready0_reg;
  assign m1_ready   = ready1_reg;
  assign m0_rdata   = (ready0_reg && resp_read) ? sram_rdata : 32'h0;
  assign m1_rdata   = (ready1_reg && resp_read) ? sram_rdata : 32'h0;
  assign bus_err    = bus_err_reg;
  assign grant_cnt0 = cnt0_reg;
  assign grant_cnt1 = cnt1_reg;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized bench for sram_bus_arbiter against a transaction-level reference model.
// Define SRAM_ARB_RR_EN for both bench and RTL to check the round-robin variant.
module tb_sram_bus_arbiter;

  localparam int MEM_WORDS = 4096;
  localparam int CNT_W     = 6;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0]      m0_addr = '0, m1_addr = '0;
  logic [31:0]      m0_wdata = '0, m1_wdata = '0;
  logic [3:0]       m0_wstrb = '0, m1_wstrb = '0;
  logic             m0_ready, m1_ready;
  logic [31:0]      m0_rdata, m1_rdata;
  logic             sram_en;
  logic [29:0]      sram_idx;
  logic [31:0]      sram_wdata;
  logic [3:0]       sram_wstrb;
  logic [31:0]      sram_rdata = '0;
  logic             bus_err;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  sram_bus_arbiter #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_idx(sram_idx), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
    .sram_rdata(sram_rdata), .bus_err(bus_err),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  // SRAM array: registered read, byte-masked write
  logic [31:0] sram [0:MEM_WORDS-1];
  always @(posedge clk) begin
    if (sram_en && sram_idx < 30'(MEM_WORDS)) begin
      sram_rdata <= sram[sram_idx[11:0]];
      for (int b = 0; b < 4; b++)
        if (sram_wstrb[b]) sram[sram_idx[11:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          drop;
  } req_t;

  req_t q0[$];
  req_t q1[$];
  req_t cur[2];
  bit   act[2];
  bit   held[2];
  int   cool[2];

  // Reference model state (one transaction in flight at most)
  logic [31:0] exp_mem [0:MEM_WORDS-1];
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          ts = -10;
  int          next_free = 0;
  int          last_m = 1;
  int          gm = 0;
  bit          live = 1'b0;
  int          exp_cnt[2];
  logic [29:0] t_idx;
  logic [31:0] t_wdata;
  logic [31:0] exp_rd;
  logic [3:0]  t_wstrb;
  bit          t_inr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) begin
`ifdef SRAM_ARB_RR_EN
      return (last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s; r.drop = 1'b0;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      r.addr = $urandom;
    else if (sel == 1) r.addr = 32'h4000 | 32'($urandom_range(0, 1023));
    else               r.addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
    r.wdata = $urandom;
    r.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    r.drop  = ($urandom_range(0, 15) == 0);
    return r;
  endfunction

  task automatic check_outputs();
    bit en_e, r0, r1, be;
    en_e = live && edge_n == ts && t_inr;
    r0   = live && edge_n == ts + 1 && gm == 0;
    r1   = live && edge_n == ts + 1 && gm == 1;
    be   = live && edge_n == ts + 1 && !t_inr;
    chk("sram_en", sram_en, en_e);
    if (en_e) begin
      chk("sram_idx", sram_idx, t_idx);
      chk("sram_wstrb", sram_wstrb, t_wstrb);
      if (t_wstrb != 4'h0) chk("sram_wdata", sram_wdata, t_wdata);
    end
    chk("m0_ready", m0_ready, r0);
    chk("m1_ready", m1_ready, r1);
    chk("m0_rdata", m0_rdata, r0 ? exp_rd : 32'h0);
    chk("m1_rdata", m1_rdata, r1 ? exp_rd : 32'h0);
    chk("bus_err", bus_err, be);
    chk("grant_cnt0", grant_cnt0, exp_cnt[0]);
    chk("grant_cnt1", grant_cnt1, exp_cnt[1]);
  endtask

  task automatic update_masters();
    bit rdy[2];
    rdy[0] = m0_ready;
    rdy[1] = m1_ready;
    for (int m = 0; m < 2; m++) begin
      if (act[m] && rdy[m]) act[m] = 1'b0;
      else if (act[m] && cur[m].drop && held[m]) begin
        act[m] = 1'b0;
        cool[m] = 3;
      end
      if (cool[m] > 0) cool[m]--;
      else if (!act[m]) begin
        if (m == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); act[0] = 1'b1; held[0] = 1'b0; end
        if (m == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); act[1] = 1'b1; held[1] = 1'b0; end
      end
    end
    m0_valid = act[0]; m0_addr = cur[0].addr; m0_wdata = cur[0].wdata; m0_wstrb = cur[0].wstrb;
    m1_valid = act[1]; m1_addr = cur[1].addr; m1_wdata = cur[1].wdata; m1_wstrb = cur[1].wstrb;
  endtask

  task automatic step();
    bit          v0, v1;
    logic [31:0] a;
    @(posedge clk);
    edge_n++;
    v0 = m0_valid;
    v1 = m1_valid;
    if (v0) held[0] = 1'b1;
    if (v1) held[1] = 1'b1;
    if (resetn) begin
      if (live && edge_n == ts + 1) begin
        exp_rd = 32'h0;
        if (t_inr) begin
          if (t_wstrb == 4'h0) exp_rd = exp_mem[t_idx[11:0]];
          else
            for (int b = 0; b < 4; b++)
              if (t_wstrb[b]) exp_mem[t_idx[11:0]][8*b +: 8] = t_wdata[8*b +: 8];
        end
      end
      if (live && edge_n == ts + 2) begin
        if (exp_cnt[gm] < CNT_MAX) exp_cnt[gm]++;
        last_m = gm;
        live = 1'b0;
      end
      if (edge_n >= next_free && (v0 || v1)) begin
        gm      = pick(v0, v1, last_m);
        a       = (gm == 1) ? m1_addr : m0_addr;
        t_idx   = a[31:2];
        t_inr   = (a[31:2] < 30'(MEM_WORDS));
        t_wdata = (gm == 1) ? m1_wdata : m0_wdata;
        t_wstrb = (gm == 1) ? m1_wstrb : m0_wstrb;
        ts = edge_n;
        next_free = edge_n + 3;
        live = 1'b1;
      end
    end
    #1;
    check_outputs();
    update_masters();
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      sram[i]    = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      exp_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    sram[5] = 32'hDEADBEEF;
    exp_mem[5] = 32'hDEADBEEF;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    act[0] = 0; act[1] = 0; held[0] = 0; held[1] = 0; cool[0] = 0; cool[1] = 0;
    cur[0] = mk_req(32'h0, 32'h0, 4'h0);
    cur[1] = mk_req(32'h0, 32'h0, 4'h0);

    // reset state, then a lone m0 read of word 5
    repeat (2) step();
    resetn = 1'b1;
    q0.push_back(mk_req(32'h14, 32'h0, 4'h0));
    repeat (5) step();
    chk("t1_cnt0", grant_cnt0, 1);

    // m1 byte write, then read it back
    q1.push_back(mk_req(32'h10, 32'h12345678, 4'b0011));
    repeat (5) step();
    q1.push_back(mk_req(32'h10, 32'h0, 4'h0));
    repeat (5) step();
    chk("t2_cnt1", grant_cnt1, 2);

    // both masters contending for several transactions
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk_req(32'($urandom_range(0, 63)) << 2, 32'h0, 4'h0));
      q1.push_back(mk_req(32'($urandom_range(0, 63)) << 2, 32'h0, 4'h0));
    end
    repeat (24) step();

    // out-of-range read
    q0.push_back(mk_req(32'h4000, 32'h0, 4'h0));
    repeat (5) step();

    // reset while the write is in ISSUE; the request must be served again afterwards
    q0.push_back(mk_req(32'h1C, 32'hCAFEF00D, 4'hF));
    for (int i = 0; i < 10 && !(live && edge_n == ts); i++) step();
    chk("t5_reached_issue", live && edge_n == ts, 1);
    #2 resetn = 1'b0;
    #1;
    live = 1'b0; exp_cnt[0] = 0; exp_cnt[1] = 0; last_m = 1; next_free = 0;
    chk("t5_rst_sram_en", sram_en, 0);
    chk("t5_rst_bus_err", bus_err, 0);
    chk("t5_rst_cnt0", grant_cnt0, 0);
    repeat (2) step();
    resetn = 1'b1;
    repeat (6) step();
    chk("t5_served", grant_cnt0, 1);
    q0.push_back(mk_req(32'h1C, 32'h0, 4'h0));
    repeat (5) step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
      step();
    end
    for (int c = 0; c < 300 && (q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || cool[0] > 0 || cool[1] > 0); c++)
      step();
    chk("drain_done", q0.size() + q1.size() + int'(act[0]) + int'(act[1]), 0);
    repeat (4) step();

    // counter saturation
    for (int k = 0; k < 80 && exp_cnt[0] < CNT_MAX; k++) begin
      q0.push_back(mk_req(32'h8, 32'h0, 4'h0));
      repeat (4) step();
    end
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk_req(32'h8, 32'h0, 4'h0));
      repeat (4) step();
    end
    chk("t6_cnt0_sat", grant_cnt0, CNT_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
